tsn_dram_cmd_responder: RTL and testbench

DRAM-side responder for the NPU's read-command (rcc), read-data (rcd) and write-command (wcc) channels. It accepts read and write burst commands from the DGCL and turns them into single-beat 128-bit accesses on one shared memory port. Read data comes back on the rcd channel, one beat at a time, each beat tagged with its DPRAM address. The block sits between the DGCL and the DRAM/AXI bridge on the gemmini clock domain.

---
 rtl/tsn_dma_pkg.sv | 27 ++
 rtl/tsn_dram_cmd_responder.sv | 179 +++++++++++++++++
 tb/tb_tsn_dram_cmd_responder.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tsn_dma_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tsn_dma_pkg : shared widths and FSM encoding for the DGCL/DRAM channels
// Revision    : 1.0
// ---------------------------------------------------------------------------
package tsn_dma_pkg;

    localparam int DRAM_AW    = 40;
    localparam int DPRAM_AW   = 16;
    localparam int LEN_W      = 16;
    localparam int BEAT_W     = 128;
    localparam int BEAT_BYTES = 16;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_REQ  = 3'd1;
    localparam logic [2:0] ST_RD_WAIT = 3'd2;
    localparam logic [2:0] ST_RD_DATA = 3'd3;
    localparam logic [2:0] ST_WR_REQ  = 3'd4;

    localparam logic GRANT_RD = 1'b0;
    localparam logic GRANT_WR = 1'b1;

endpackage
`default_nettype wire

// File: rtl/tsn_dram_cmd_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tsn_dram_cmd_responder : turns rcc/wcc bursts into single-beat accesses on
//                          one shared memory port; read beats return on rcd
// Revision               : 1.0
// ---------------------------------------------------------------------------
module tsn_dram_cmd_responder #(
    parameter int BEAT_BYTES = tsn_dma_pkg::BEAT_BYTES
) (
    input  logic                               gemmini_clk,
    input  logic                               reset_n,

    input  logic [tsn_dma_pkg::DRAM_AW-1:0]    rcc_dram_addr,
    input  logic [tsn_dma_pkg::DPRAM_AW-1:0]   rcc_dpram_addr,
    input  logic [tsn_dma_pkg::LEN_W-1:0]      rcc_length,
    input  logic                               rcc_valid,
    output logic                               rcc_ready,

    output logic [tsn_dma_pkg::DPRAM_AW-1:0]   rcd_dpram_addr,
    output logic [tsn_dma_pkg::BEAT_W-1:0]     rcd_read_data,
    output logic [tsn_dma_pkg::LEN_W-1:0]      rcd_length,
    output logic                               rcd_valid,
    input  logic                               rcd_ready,

    input  logic [tsn_dma_pkg::DRAM_AW-1:0]    wcc_dram_addr,
    input  logic [tsn_dma_pkg::DPRAM_AW-1:0]   wcc_dpram_addr,
    input  logic [tsn_dma_pkg::LEN_W-1:0]      wcc_length,
    input  logic [tsn_dma_pkg::BEAT_W-1:0]     wcc_write_data,
    input  logic                               wcc_valid,
    output logic                               wcc_ready,

    output logic                               mem_req,
    output logic                               mem_we,
    output logic [tsn_dma_pkg::DRAM_AW-1:0]    mem_addr,
    output logic [tsn_dma_pkg::BEAT_W-1:0]     mem_wdata,
    input  logic                               mem_gnt,
    input  logic                               mem_rvalid,
    input  logic [tsn_dma_pkg::BEAT_W-1:0]     mem_rdata,

    output logic                               busy
);
    import tsn_dma_pkg::*;

    localparam logic [DRAM_AW-1:0] ADDR_STEP = DRAM_AW'(BEAT_BYTES);

    logic [2:0]          state;
    logic                out_en;
    logic                last_grant;
    logic [DRAM_AW-1:0]  rd_addr;
    logic [DPRAM_AW-1:0] rd_dp;
    logic [LEN_W-1:0]    rd_len;
    logic [LEN_W-1:0]    rd_rem;
    logic [DRAM_AW-1:0]  wr_addr;
    logic [LEN_W-1:0]    wr_rem;
    logic [BEAT_W-1:0]   wr_data;

    logic                rd_pend;
    logic                wr_pend;
    logic                win_rd;
    logic                win_wr;
    logic                rcc_fire;
    logic                wr_first;
    logic [LEN_W-1:0]    wr_len_m1;
    logic                unused_dpram;

    assign unused_dpram = ^wcc_dpram_addr;

    // out_en keeps the handshake outputs low while reset is held and until
    // the first clock edge after release, without looking at reset_n itself.
    assign rd_pend   = (rd_rem != '0);
    assign wr_pend   = wcc_valid;
    assign win_rd    = out_en && (state == ST_IDLE) && rd_pend
                       && (!wr_pend || (last_grant == GRANT_WR));
    assign win_wr    = out_en && (state == ST_IDLE) && wr_pend
                       && (!rd_pend || (last_grant == GRANT_RD));

    assign rcc_ready = out_en && (state == ST_IDLE) && !rd_pend;
    assign wcc_ready = win_wr;
    assign rcc_fire  = rcc_valid && rcc_ready;

    assign wr_first  = (wr_rem == '0);
    assign wr_len_m1 = (wcc_length == '0) ? '0 : (wcc_length - LEN_W'(1));

    assign rcd_valid = (state == ST_RD_DATA);
    assign mem_req   = (state == ST_RD_REQ) || (state == ST_WR_REQ);
    assign mem_we    = (state == ST_WR_REQ);
    assign mem_wdata = mem_we ? wr_data : '0;
    assign busy      = (state != ST_IDLE) || rd_pend || (wr_rem != '0);

    always_comb begin
        mem_addr = '0;
        if (state == ST_RD_REQ) begin
            mem_addr = rd_addr;
        end else if (state == ST_WR_REQ) begin
            mem_addr = wr_addr;
        end
    end

    always_ff @(posedge gemmini_clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            out_en         <= 1'b0;
            last_grant     <= GRANT_WR;
            rd_addr        <= '0;
            rd_dp          <= '0;
            rd_len         <= '0;
            rd_rem         <= '0;
            wr_addr        <= '0;
            wr_rem         <= '0;
            wr_data        <= '0;
            rcd_dpram_addr <= '0;
            rcd_read_data  <= '0;
            rcd_length     <= '0;
        end else begin
            out_en <= 1'b1;

            // rcc can only fire with no read outstanding, so it never
            // collides with the read-side updates below.
            if (rcc_fire) begin
                rd_addr <= rcc_dram_addr;
                rd_dp   <= rcc_dpram_addr;
                rd_len  <= rcc_length;
                rd_rem  <= rcc_length;
            end

            case (state)
                ST_IDLE: begin
                    if (win_rd) begin
                        state      <= ST_RD_REQ;
                        last_grant <= GRANT_RD;
                    end else if (win_wr) begin
                        state      <= ST_WR_REQ;
                        last_grant <= GRANT_WR;
                        wr_data    <= wcc_write_data;
                        if (wr_first) begin
                            wr_addr <= wcc_dram_addr;
                            wr_rem  <= wr_len_m1;
                        end else begin
                            wr_addr <= wr_addr + ADDR_STEP;
                            wr_rem  <= wr_rem - LEN_W'(1);
                        end
                    end
                end
                ST_RD_REQ: begin
                    if (mem_gnt) begin
                        state <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    if (mem_rvalid) begin
                        rcd_read_data  <= mem_rdata;
                        rcd_dpram_addr <= rd_dp;
                        rcd_length     <= rd_len;
                        state          <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (rcd_ready) begin
                        rd_rem  <= rd_rem - LEN_W'(1);
                        rd_addr <= rd_addr + ADDR_STEP;
                        rd_dp   <= rd_dp + DPRAM_AW'(1);
                        state   <= ST_IDLE;
                    end
                end
                ST_WR_REQ: begin
                    if (mem_gnt) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tsn_dram_cmd_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_tsn_dram_cmd_responder : directed vector bench with a small memory model
// Revision                  : 1.0
// ---------------------------------------------------------------------------
module tb_tsn_dram_cmd_responder;

    logic         gemmini_clk = 1'b0;
    logic         reset_n     = 1'b0;
    logic [39:0]  rcc_dram_addr  = '0;
    logic [15:0]  rcc_dpram_addr = '0;
    logic [15:0]  rcc_length     = '0;
    logic         rcc_valid      = 1'b0;
    logic         rcc_ready;
    logic [15:0]  rcd_dpram_addr;
    logic [127:0] rcd_read_data;
    logic [15:0]  rcd_length;
    logic         rcd_valid;
    logic         rcd_ready      = 1'b1;
    logic [39:0]  wcc_dram_addr  = '0;
    logic [15:0]  wcc_dpram_addr = '0;
    logic [15:0]  wcc_length     = '0;
    logic [127:0] wcc_write_data = '0;
    logic         wcc_valid      = 1'b0;
    logic         wcc_ready;
    logic         mem_req;
    logic         mem_we;
    logic [39:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic         mem_gnt;
    logic         mem_rvalid;
    logic [127:0] mem_rdata;
    logic         busy;

    always #5 gemmini_clk = ~gemmini_clk;

    tsn_dram_cmd_responder #(.BEAT_BYTES(16)) dut (
        .gemmini_clk    (gemmini_clk),
        .reset_n        (reset_n),
        .rcc_dram_addr  (rcc_dram_addr),
        .rcc_dpram_addr (rcc_dpram_addr),
        .rcc_length     (rcc_length),
        .rcc_valid      (rcc_valid),
        .rcc_ready      (rcc_ready),
        .rcd_dpram_addr (rcd_dpram_addr),
        .rcd_read_data  (rcd_read_data),
        .rcd_length     (rcd_length),
        .rcd_valid      (rcd_valid),
        .rcd_ready      (rcd_ready),
        .wcc_dram_addr  (wcc_dram_addr),
        .wcc_dpram_addr (wcc_dpram_addr),
        .wcc_length     (wcc_length),
        .wcc_write_data (wcc_write_data),
        .wcc_valid      (wcc_valid),
        .wcc_ready      (wcc_ready),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_gnt        (mem_gnt),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .busy           (busy)
    );

    // Memory model: grant after gnt_lat wait cycles, read data one cycle
    // after grant, numbered rdata_base + n for the n-th read since clear.
    int           gnt_lat    = 0;
    logic [127:0] rdata_base = '0;
    logic         clr_log    = 1'b0;
    int           wait_cnt   = 0;
    int           rd_idx     = 0;
    int           stab_err   = 0;
    logic         rv         = 1'b0;
    logic [127:0] rv_data    = '0;
    logic         prev_wait  = 1'b0;
    logic [39:0]  prev_addr  = '0;
    logic         prev_we    = 1'b0;
    logic [127:0] prev_wdata = '0;

    logic         log_we[$];
    logic [39:0]  log_addr[$];
    logic [127:0] log_wdata[$];
    logic [15:0]  rcd_dp_q[$];
    logic [127:0] rcd_data_q[$];
    logic [15:0]  rcd_len_q[$];

    assign mem_gnt    = mem_req && (wait_cnt >= gnt_lat);
    assign mem_rvalid = rv;
    assign mem_rdata  = rv_data;

    always @(posedge gemmini_clk) begin
        if (clr_log) begin
            log_we.delete(); log_addr.delete(); log_wdata.delete();
            rcd_dp_q.delete(); rcd_data_q.delete(); rcd_len_q.delete();
            rd_idx   <= 0;
            stab_err <= 0;
        end else begin
            if (mem_req && mem_gnt) begin
                log_we.push_back(mem_we);
                log_addr.push_back(mem_addr);
                log_wdata.push_back(mem_wdata);
                if (!mem_we) rd_idx <= rd_idx + 1;
            end
            if (rcd_valid && rcd_ready) begin
                rcd_dp_q.push_back(rcd_dpram_addr);
                rcd_data_q.push_back(rcd_read_data);
                rcd_len_q.push_back(rcd_length);
            end
            if (prev_wait && mem_req &&
                (mem_addr != prev_addr || mem_we != prev_we || mem_wdata != prev_wdata))
                stab_err <= stab_err + 1;
        end
        rv         <= mem_req && mem_gnt && !mem_we;
        rv_data    <= rdata_base + 128'(rd_idx);
        wait_cnt   <= (mem_req && !mem_gnt) ? wait_cnt + 1 : 0;
        prev_wait  <= mem_req && !mem_gnt;
        prev_addr  <= mem_addr;
        prev_we    <= mem_we;
        prev_wdata <= mem_wdata;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int idx,
                         input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge gemmini_clk);
        reset_n = 1'b0;
        repeat (2) @(negedge gemmini_clk);
        reset_n = 1'b1;
        @(negedge gemmini_clk);
    endtask

    task automatic clear_log();
        clr_log = 1'b1;
        @(negedge gemmini_clk);
        clr_log = 1'b0;
    endtask

    task automatic send_rcc(input logic [39:0] a, input logic [15:0] dp, input logic [15:0] l);
        bit ok = 0;
        for (int c = 0; c < 300; c++) begin
            if (rcc_ready) begin ok = 1; break; end
            @(negedge gemmini_clk);
        end
        check("rcc_ready_timeout", 0, 128'(ok), 128'(1));
        rcc_dram_addr = a; rcc_dpram_addr = dp; rcc_length = l; rcc_valid = 1'b1;
        @(negedge gemmini_clk);
        rcc_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [39:0] a, input logic [15:0] l, input logic [127:0] d);
        bit ok = 0;
        wcc_dram_addr = a; wcc_length = l; wcc_write_data = d; wcc_valid = 1'b1;
        for (int c = 0; c < 300; c++) begin
            #1;
            if (wcc_ready) begin ok = 1; break; end
            @(negedge gemmini_clk);
        end
        @(negedge gemmini_clk);
        wcc_valid = 1'b0;
        check("wcc_ready_timeout", 0, 128'(ok), 128'(1));
    endtask

    task automatic wait_idle(input int idx);
        bit ok = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!busy) begin ok = 1; break; end
            @(negedge gemmini_clk);
        end
        repeat (4) @(negedge gemmini_clk);
        check("idle_timeout", idx, 128'(ok), 128'(1));
    endtask

    typedef struct {
        logic         is_wr;
        logic [39:0]  addr;
        logic [15:0]  dp;
        logic [15:0]  len;
        logic [127:0] data_base;
        int           lat;
        int           exp_beats;
        int           exp_mem;
        logic [39:0]  exp_first;
        logic [39:0]  exp_last;
        logic [127:0] exp_data;
        logic [15:0]  exp_dp;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int nb;
        int wec;
        bit okv;
        logic [7:0]   pat;
        logic [15:0]  hold_dp;
        logic [127:0] hold_data;
        int           viol;
        int           wn;

        vecs[0] = '{1'b0, 40'h10_0000_0000, 16'h0040, 16'd3, 128'hA0, 0, 3, 3,
                    40'h10_0000_0000, 40'h10_0000_0020, 128'hA2, 16'h0042};
        vecs[1] = '{1'b0, 40'h00_0000_0500, 16'h0001, 16'd0, 128'h10, 0, 0, 0,
                    40'h0, 40'h0, 128'h0, 16'h0};
        vecs[2] = '{1'b1, 40'hFF_FFFF_FFF0, 16'h0000, 16'd2, 128'hB0, 2, 0, 2,
                    40'hFF_FFFF_FFF0, 40'h00_0000_0000, 128'hB1, 16'h0};
        vecs[3] = '{1'b1, 40'h00_1234_5670, 16'h0000, 16'd0, 128'hC0, 1, 0, 1,
                    40'h00_1234_5670, 40'h00_1234_5670, 128'hC0, 16'h0};
        vecs[4] = '{1'b0, 40'hFF_FFFF_FFF0, 16'hFFFF, 16'd2, 128'hD0, 1, 2, 2,
                    40'hFF_FFFF_FFF0, 40'h00_0000_0000, 128'hD1, 16'h0000};
        vecs[5] = '{1'b1, 40'h00_0000_0040, 16'h0000, 16'd3, 128'hE0, 0, 0, 3,
                    40'h00_0000_0040, 40'h00_0000_0060, 128'hE2, 16'h0};

        // Reset state, with both command valids raised to see ready stay low.
        rcc_valid = 1'b1; wcc_valid = 1'b1;
        repeat (3) @(negedge gemmini_clk);
        check("rst_rcc_ready", 0, 128'(rcc_ready), 128'(0));
        check("rst_wcc_ready", 0, 128'(wcc_ready), 128'(0));
        check("rst_rcd_valid", 0, 128'(rcd_valid), 128'(0));
        check("rst_mem_req",   0, 128'(mem_req),   128'(0));
        check("rst_mem_we",    0, 128'(mem_we),    128'(0));
        check("rst_busy",      0, 128'(busy),      128'(0));
        check("rst_mem_addr",  0, 128'(mem_addr),  128'(0));
        check("rst_rcd_data",  0, rcd_read_data,   128'(0));
        check("rst_rcd_dp",    0, 128'(rcd_dpram_addr), 128'(0));
        rcc_valid = 1'b0; wcc_valid = 1'b0;
        reset_n = 1'b1;
        @(negedge gemmini_clk);
        check("rcc_ready_after_rst", 0, 128'(rcc_ready), 128'(1));

        // Read latency: handshake c0, arbitration c1, mem_req c2, rcd_valid c4.
        gnt_lat = 0; rdata_base = 128'h5A; clear_log();
        send_rcc(40'h00_0000_0400, 16'h0007, 16'd1);
        check("lat_c1_req",   0, 128'(mem_req), 128'(0));
        @(negedge gemmini_clk);
        check("lat_c2_req",   0, 128'(mem_req), 128'(1));
        check("lat_c2_addr",  0, 128'(mem_addr), 128'(40'h400));
        check("lat_c2_we",    0, 128'(mem_we), 128'(0));
        @(negedge gemmini_clk);
        check("lat_c3_valid", 0, 128'(rcd_valid), 128'(0));
        @(negedge gemmini_clk);
        check("lat_c4_valid", 0, 128'(rcd_valid), 128'(1));
        check("lat_c4_data",  0, rcd_read_data, 128'h5A);
        check("lat_c4_dp",    0, 128'(rcd_dpram_addr), 128'(16'h0007));
        wait_idle(100);

        for (int i = 0; i < 6; i++) begin
            gnt_lat = vecs[i].lat;
            rdata_base = vecs[i].data_base;
            clear_log();
            if (!vecs[i].is_wr) begin
                send_rcc(vecs[i].addr, vecs[i].dp, vecs[i].len);
            end else begin
                nb = (vecs[i].len == 16'd0) ? 1 : int'(vecs[i].len);
                for (int b = 0; b < nb; b++)
                    send_beat((b == 0) ? vecs[i].addr : 40'hAB_CDEF_0000,
                              (b == 0) ? vecs[i].len  : 16'h7777,
                              vecs[i].data_base + 128'(b));
            end
            wait_idle(i);
            wec = 0;
            foreach (log_we[k]) if (log_we[k]) wec++;
            check("beats",     i, 128'(rcd_dp_q.size()), 128'(vecs[i].exp_beats));
            check("mem_count", i, 128'(log_addr.size()), 128'(vecs[i].exp_mem));
            check("we_count",  i, 128'(wec), vecs[i].is_wr ? 128'(vecs[i].exp_mem) : 128'(0));
            check("stable",    i, 128'(stab_err), 128'(0));
            if (log_addr.size() > 0 && vecs[i].exp_mem > 0) begin
                check("first_addr", i, 128'(log_addr[0]), 128'(vecs[i].exp_first));
                check("last_addr",  i, 128'(log_addr[log_addr.size()-1]), 128'(vecs[i].exp_last));
            end
            if (vecs[i].is_wr && log_wdata.size() > 0)
                check("last_wdata", i, log_wdata[log_wdata.size()-1], vecs[i].exp_data);
            if (!vecs[i].is_wr && rcd_dp_q.size() > 0) begin
                check("last_dp",   i, 128'(rcd_dp_q[rcd_dp_q.size()-1]), 128'(vecs[i].exp_dp));
                check("last_data", i, rcd_data_q[rcd_data_q.size()-1], vecs[i].exp_data);
                check("rcd_len",   i, 128'(rcd_len_q[rcd_len_q.size()-1]), 128'(vecs[i].len));
            end
        end

        // Backpressure: hold rcd_ready low for 10 cycles on the second beat.
        gnt_lat = 0; rdata_base = 128'h50; clear_log();
        rcd_ready = 1'b0; viol = 0;
        send_rcc(40'h00_0000_0300, 16'h0010, 16'd3);
        for (int k = 0; k < 3; k++) begin
            okv = 0;
            for (int c = 0; c < 100; c++) begin
                if (rcd_valid) begin okv = 1; break; end
                @(negedge gemmini_clk);
            end
            check("bp_valid_timeout", k, 128'(okv), 128'(1));
            if (k == 1) begin
                hold_dp = rcd_dpram_addr; hold_data = rcd_read_data;
                repeat (10) begin
                    @(negedge gemmini_clk);
                    if (!rcd_valid || mem_req || rcd_dpram_addr != hold_dp ||
                        rcd_read_data != hold_data) viol++;
                end
            end
            rcd_ready = 1'b1;
            @(negedge gemmini_clk);
            rcd_ready = 1'b0;
        end
        rcd_ready = 1'b1;
        wait_idle(200);
        check("bp_violations", 0, 128'(viol), 128'(0));
        check("bp_beats",      0, 128'(rcd_dp_q.size()), 128'(3));
        if (rcd_dp_q.size() == 3) begin
            check("bp_dp1",   0, 128'(rcd_dp_q[1]), 128'(16'h0011));
            check("bp_data2", 0, rcd_data_q[2], 128'h52);
        end

        // Arbitration: read len 4 against a continuously valid write stream.
        do_reset();
        gnt_lat = 0; rdata_base = 128'h0; clear_log();
        send_rcc(40'h00_0000_1000, 16'h0000, 16'd4);
        wcc_length = 16'd0; wcc_dram_addr = 40'h00_0000_9000;
        wcc_write_data = 128'hF0; wcc_valid = 1'b1; wn = 0;
        for (int c = 0; c < 300 && wn < 4; c++) begin
            #1;
            if (wcc_ready) wn++;
            @(negedge gemmini_clk);
            if (wn == 4) wcc_valid = 1'b0;
        end
        wcc_valid = 1'b0;
        wait_idle(300);
        check("arb_count", 0, 128'(log_we.size()), 128'(8));
        pat = '0;
        for (int k = 0; k < 8 && k < log_we.size(); k++) pat[k] = log_we[k];
        check("arb_pattern", 0, 128'(pat), 128'(8'b1010_1010));
        check("arb_beats",   0, 128'(rcd_dp_q.size()), 128'(4));

        // Reset pulsed while waiting for read data.
        gnt_lat = 0; rdata_base = 128'h33; clear_log();
        send_rcc(40'h00_0000_0700, 16'h0002, 16'd2);
        repeat (2) @(negedge gemmini_clk);
        check("rdwait_busy",  0, 128'(busy && !mem_req && !rcd_valid), 128'(1));
        reset_n = 1'b0;
        #1;
        check("midrst_busy",  0, 128'(busy), 128'(0));
        check("midrst_valid", 0, 128'(rcd_valid), 128'(0));
        repeat (2) @(negedge gemmini_clk);
        reset_n = 1'b1;
        repeat (6) @(negedge gemmini_clk);
        check("midrst_beats", 0, 128'(rcd_dp_q.size()), 128'(0));
        check("midrst_idle",  0, 128'(busy), 128'(0));
        rdata_base = 128'h77; clear_log();
        send_rcc(40'h00_0000_0800, 16'h0009, 16'd1);
        wait_idle(400);
        check("post_rst_beats", 0, 128'(rcd_dp_q.size()), 128'(1));
        if (rcd_dp_q.size() == 1) begin
            check("post_rst_data", 0, rcd_data_q[0], 128'h77);
            check("post_rst_dp",   0, 128'(rcd_dp_q[0]), 128'(16'h0009));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
